infoframe_packet_gen: RTL

Runtime-programmable HDMI InfoFrame packet source, the parametrised successor of the fixed audio InfoFrame constant block. Software or a config FSM writes payload bytes into a shadow buffer and commits them. A sequential checksum engine then swaps the bytes into an active buffer. The active buffer is offered once per video frame to the data-island packet scheduler over a valid/ready handshake. Any InfoFrame type (AVI, audio, SPD, vendor) is produced by changing parameters.

---
 rtl/infoframe_packet_gen.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/infoframe_packet_gen.sv
// infoframe_packet_gen
// Runtime-programmable HDMI InfoFrame source. Payload bytes are written into a
// shadow buffer, a commit runs a byte-serial checksum over them, and the result
// is swapped into an active buffer. The active buffer is offered once per video
// frame over a valid/ready handshake.
//
// Optional feature macro: INFOFRAME_DEFAULT_AUDIO_EN
//   When defined, reset preloads a 2-channel audio payload (PB1 = 8'h01) with a
//   matching checksum, so packets flow from the first frame_start without any
//   programming.
module infoframe_packet_gen #(
  parameter logic [7:0] TYPE    = 8'h84,
  parameter logic [7:0] VERSION = 8'h01,
  parameter logic [4:0] LENGTH  = 5'd10
) (
  input  logic         clk_pixel,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [7:0]   cfg_wdata,
  input  logic         cfg_commit,
  output logic         cfg_busy,
  input  logic         frame_start,
  input  logic         pkt_ready,
  output logic         pkt_valid,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic         overrun
);

  // Two's-complement checksum byte that makes the running sum wrap to zero.
  function automatic logic [7:0] pb0_f(input logic [7:0] sum);
    return ~sum + 8'h01;
  endfunction

  // Byte mask selecting PB1..PB[len]; bytes past the payload are forced to zero.
  function automatic logic [215:0] payload_mask_f(input logic [4:0] len);
    logic [215:0] m;
    m = '0;
    for (int i = 1; i < 28; i++) begin
      if (i <= int'(len)) begin
        m[8*(i-1) +: 8] = 8'hFF;
      end else begin
        m[8*(i-1) +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  // Header contribution to the checksum, folded once at elaboration.
  localparam logic [7:0]   HDR_SUM      = TYPE + VERSION + {3'b000, LENGTH};
  localparam logic [215:0] PAYLOAD_MASK = payload_mask_f(LENGTH);

`ifdef INFOFRAME_DEFAULT_AUDIO_EN
  localparam logic [223:0] SHADOW_RST       = {208'h0, 8'h01, 8'h00};
  localparam logic [223:0] ACTIVE_RST       = {208'h0, 8'h01, pb0_f(HDR_SUM + 8'h01)};
  localparam logic         ACTIVE_VALID_RST = 1'b1;
`else
  localparam logic [223:0] SHADOW_RST       = 224'h0;
  localparam logic [223:0] ACTIVE_RST       = 224'h0;
  localparam logic         ACTIVE_VALID_RST = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [4:0]     idx_r;
  logic [7:0]     acc_r;
  logic [223:0]   shadow_r;       // byte 0 is never written; PB1..PB27 live above it
  logic [223:0]   active_r;
  logic           active_valid_r;
  logic           pending_r;
  logic           busy_r;
  logic           pkt_valid_r;
  logic           overrun_r;

  logic           start_sum_s;
  logic           publish_s;
  logic           wr_ok_s;
  logic [7:0]     cur_byte_s;
  logic [223:0]   publish_img_s;

  assign header    = {3'b000, LENGTH, VERSION, TYPE};
  assign sub       = active_r;
  assign cfg_busy  = busy_r;
  assign pkt_valid = pkt_valid_r;
  assign overrun   = overrun_r;

  // Shadow writes are only accepted while idle and for byte indices 1..27.
  assign wr_ok_s    = cfg_we && (state_r == ST_IDLE) &&
                      (cfg_addr != 5'd0) && (cfg_addr <= 5'd27);
  assign cur_byte_s = shadow_r[{idx_r, 3'b000} +: 8];

  // Image written to the active buffer on publish: masked payload plus checksum.
  always_comb begin
    publish_img_s        = '0;
    publish_img_s[223:8] = shadow_r[223:8] & PAYLOAD_MASK;
    publish_img_s[7:0]   = pb0_f(acc_r);
  end

  // FSM next-state: sequence commit -> checksum -> publish, stalling the swap under an open offer.
  always_comb begin
    state_s     = state_r;
    start_sum_s = 1'b0;
    publish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_commit || pending_r) begin
          state_s     = ST_SUM;
          start_sum_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SUM: begin
        if (idx_r == LENGTH) begin
          state_s = ST_SWAP;
        end else begin
          state_s = ST_SUM;
        end
      end
      ST_SWAP: begin
        if (pkt_valid_r && !pkt_ready) begin
          state_s = ST_SWAP;
        end else begin
          state_s   = ST_IDLE;
          publish_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register and the registered busy flag derived from the next state.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Commits arriving while busy collapse into a single pending request.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if ((state_r != ST_IDLE) && cfg_commit) begin
      pending_r <= 1'b1;
    end else if (start_sum_s) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Byte-serial checksum accumulator, seeded with the header sum on entry to SUM.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 8'h00;
      idx_r <= 5'd0;
    end else if (start_sum_s) begin
      acc_r <= HDR_SUM;
      idx_r <= 5'd1;
    end else if (state_r == ST_SUM) begin
      acc_r <= acc_r + cur_byte_s;
      idx_r <= idx_r + 5'd1;
    end else begin
      acc_r <= acc_r;
      idx_r <= idx_r;
    end
  end

  // Shadow payload buffer written by the configuration port.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= SHADOW_RST;
    end else if (wr_ok_s) begin
      shadow_r[{cfg_addr, 3'b000} +: 8] <= cfg_wdata;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active buffer only changes on publish, which never happens under an outstanding offer.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      active_r       <= ACTIVE_RST;
      active_valid_r <= ACTIVE_VALID_RST;
    end else if (publish_s) begin
      active_r       <= publish_img_s;
      active_valid_r <= 1'b1;
    end else begin
      active_r       <= active_r;
      active_valid_r <= active_valid_r;
    end
  end

  // Per-frame offer handshake with a sticky overrun flag for unserved frames.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (pkt_valid_r) begin
      if (pkt_ready) begin
        pkt_valid_r <= frame_start && active_valid_r;
        overrun_r   <= overrun_r;
      end else begin
        pkt_valid_r <= 1'b1;
        overrun_r   <= overrun_r || frame_start;
      end
    end else begin
      pkt_valid_r <= frame_start && active_valid_r;
      overrun_r   <= overrun_r;
    end
  end

endmodule
